msrh_l2_req_arbiter: RTL and testbench

MSRH_L2_REQ_ARBITER -- requirements
Module: msrh_l2_req_arbiter

---
 rtl/msrh_lsu_pkg.sv | 32 +++
 rtl/l2_req_if.sv | 9 +
 rtl/msrh_l2_req_skid_fifo.sv | 56 +++++
 rtl/msrh_l2_req_arbiter.sv | 98 +++++++++
 tb/tb_msrh_l2_req_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/msrh_lsu_pkg.sv
// LSU-side L2 request types, tags and requester indices shared by the L2 request path.
package msrh_lsu_pkg;

  localparam int unsigned L2_ADDR_W = 32;
  localparam int unsigned L2_DATA_W = 64;
  localparam int unsigned L2_TAG_W  = 4;
  localparam int unsigned L2_BE_W   = L2_DATA_W / 8;

  // Requester indices; lower index is not higher priority, arbitration is round-robin.
  localparam int unsigned L2_REQ_IDX_L1D_EVICT = 0;
  localparam int unsigned L2_REQ_IDX_L1D_MISS  = 1;
  localparam int unsigned L2_REQ_IDX_PTW       = 2;
  localparam int unsigned L2_REQ_NUM           = 3;

  localparam logic [L2_TAG_W-1:0] L2_TAG_L1D_EVICT = 4'h0;
  localparam logic [L2_TAG_W-1:0] L2_TAG_L1D_MISS  = 4'h1;
  localparam logic [L2_TAG_W-1:0] L2_TAG_PTW       = 4'h2;

  typedef enum logic {
    L2_CMD_RD = 1'b0,
    L2_CMD_WR = 1'b1
  } l2_cmd_t;

  typedef struct packed {
    l2_cmd_t                cmd;
    logic [L2_ADDR_W-1:0]   addr;
    logic [L2_TAG_W-1:0]    tag;
    logic [L2_DATA_W-1:0]   data;
    logic [L2_BE_W-1:0]     byte_en;
  } l2_req_t;

endpackage

// File: rtl/l2_req_if.sv
// Valid/ready L2 request channel carrying one l2_req_t per transfer.
interface l2_req_if;
  logic                  valid;
  logic                  ready;
  msrh_lsu_pkg::l2_req_t payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/msrh_l2_req_skid_fifo.sv
// Small output skid FIFO; DEPTH must be a power of two so pointers wrap naturally.
module msrh_l2_req_skid_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_push,
  input  T                             i_push_data,
  input  logic                         i_pop,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output T                             o_head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T                r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  // Pointer and occupancy bookkeeping; push+pop together keeps count and advances both.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is write-only-on-push and needs no reset.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_tail] <= i_push_data;
  end

  // Flag overflow/underflow, which the surrounding logic must never cause.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(i_pop && (r_count == '0)));
      assert (!(i_push && (r_count == CW'(DEPTH))));
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

endmodule

// File: rtl/msrh_l2_req_arbiter.sv
// Round-robin arbiter of LSU L2 requesters into a registered 2-entry output skid FIFO.
module msrh_l2_req_arbiter
  import msrh_lsu_pkg::*;
#(
  parameter int unsigned REQ_NUM    = L2_REQ_NUM,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  l2_req_if.slave                     req_if [REQ_NUM],
  l2_req_if.master                    l2_req,
  output logic [$clog2(REQ_NUM)-1:0]  o_grant_id
);

  localparam int unsigned IDW = $clog2(REQ_NUM);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [IDW-1:0] id;
    l2_req_t        payload;
  } entry_t;

  // First valid requester at or after start, wrapping past REQ_NUM-1 to 0.
  function automatic logic [IDW-1:0] rr_pick(input logic [REQ_NUM-1:0] valid,
                                             input logic [IDW-1:0]     start);
    logic           found;
    logic [IDW-1:0] pick;
    int unsigned    idx;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      idx = (32'(start) + k) % REQ_NUM;
      if (!found && valid[IDW'(idx)]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
    return pick;
  endfunction

  logic [REQ_NUM-1:0] w_req_valid;
  l2_req_t            w_req_payload [REQ_NUM];
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     w_winner;
  logic               w_accept_ok;
  logic               w_push;
  logic               w_pop;
  logic [CW-1:0]      w_count;
  entry_t             w_push_entry;
  entry_t             w_head;

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_req
    assign w_req_valid[g]   = req_if[g].valid;
    assign w_req_payload[g] = req_if[g].payload;
    assign req_if[g].ready  = w_push && (w_winner == IDW'(g));
  end

  // Acceptance looks only at registered occupancy, never at l2_req.ready.
  assign w_accept_ok = !i_reset && (w_count < CW'(FIFO_DEPTH));
  assign w_winner    = rr_pick(w_req_valid, r_rr_ptr);
  assign w_push      = w_accept_ok && (|w_req_valid);

  // Tag the winning payload with its requester index for the FIFO.
  always_comb begin
    w_push_entry         = '0;
    w_push_entry.id      = w_winner;
    w_push_entry.payload = w_req_payload[w_winner];
  end

  // Pointer moves past the winner on acceptance and holds otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= IDW'((32'(w_winner) + 1) % REQ_NUM);
    end
  end

  msrh_l2_req_skid_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign l2_req.valid   = !i_reset && (w_count != '0);
  assign w_pop          = l2_req.valid && l2_req.ready;
  assign l2_req.payload = w_head.payload;
  // Head id is unreset storage, so it is masked while nothing is presented.
  assign o_grant_id     = l2_req.valid ? w_head.id : '0;

endmodule

// File: tb/tb_msrh_l2_req_arbiter.sv
// Randomized scoreboard bench for msrh_l2_req_arbiter with a queue-based reference model.
module tb_msrh_l2_req_arbiter;
  import msrh_lsu_pkg::*;

  localparam int NREQ = 3;
  localparam int EW   = $bits(l2_req_t) + 2;

  logic            clk;
  logic            tb_reset;
  logic [NREQ-1:0] tb_vld;
  l2_req_t         tb_pl [NREQ];
  logic            tb_l2_rdy;
  logic [NREQ-1:0] dut_rdy;
  logic [1:0]      o_grant_id;

  l2_req_if req_if [NREQ] ();
  l2_req_if l2_req ();

  for (genvar g = 0; g < NREQ; g++) begin : g_drv
    assign req_if[g].valid   = tb_vld[g];
    assign req_if[g].payload = tb_pl[g];
    assign dut_rdy[g]        = req_if[g].ready;
  end
  assign l2_req.ready = tb_l2_rdy;

  msrh_l2_req_arbiter #(.REQ_NUM(NREQ), .FIFO_DEPTH(2)) dut (
    .i_clk      (clk),
    .i_reset    (tb_reset),
    .req_if     (req_if),
    .l2_req     (l2_req),
    .o_grant_id (o_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  logic [EW-1:0] sb [$];
  int            glog [$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_log(input string nm, input int exp[$]);
    check({nm, "_count"}, 128'(glog.size()), 128'(exp.size()));
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      check(nm, 128'(glog[i]), 128'(exp[i]));
  endtask

  function automatic l2_req_t rnd_pl();
    l2_req_t p;
    p.cmd     = l2_cmd_t'($urandom_range(0, 1));
    p.addr    = $urandom;
    p.tag     = 4'($urandom);
    p.data    = {$urandom, $urandom};
    p.byte_en = 8'($urandom);
    return p;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: occupancy count, round-robin start, expected-entry queue.
  initial begin
    int occ, rr, best, bestd, d;
    logic acc, pop;
    logic [NREQ-1:0] exp_rdy;
    logic [1:0] bid;
    occ = 0;
    rr  = 0;
    forever begin
      @(negedge clk);
      if (tb_reset) begin
        check("reset_req_ready", 128'(dut_rdy), 128'(0));
        check("reset_l2_valid", 128'(l2_req.valid), 128'(0));
        check("reset_grant_id", 128'(o_grant_id), 128'(0));
        occ = 0;
        rr  = 0;
        sb.delete();
      end else begin
        check("l2_valid", 128'(l2_req.valid), 128'(occ > 0));
        best  = -1;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
          d = (i + NREQ - rr) % NREQ;
          if (tb_vld[i] && d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
        acc     = (best >= 0) && (occ < 2);
        exp_rdy = acc ? NREQ'(1 << best) : '0;
        check("req_ready", 128'(dut_rdy), 128'(exp_rdy));
        pop = (occ > 0) && tb_l2_rdy;
        if (acc) begin
          bid = best[1:0];
          sb.push_back({bid, tb_pl[best]});
          rr = (best + 1) % NREQ;
        end
        occ = occ + int'(acc) - int'(pop);
      end
    end
  end

  // Monitor: every presented head is compared with the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!tb_reset && l2_req.valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL l2_unexpected actual=%0h required=no_entry", {o_grant_id, l2_req.payload});
        end else begin
          check("l2_head", 128'({o_grant_id, l2_req.payload}), 128'(sb[0]));
          if (tb_l2_rdy) begin
            void'(sb.pop_front());
            glog.push_back(int'(o_grant_id));
          end
        end
      end
    end
  end

  initial begin
    tb_reset  = 1'b1;
    tb_vld    = '0;
    tb_l2_rdy = 1'b0;
    for (int i = 0; i < NREQ; i++) tb_pl[i] = rnd_pl();
    cyc(3);
    tb_reset = 1'b0;

    // All valid, sink always ready: strict rotation at full rate.
    glog.delete();
    tb_vld    = 3'b111;
    tb_l2_rdy = 1'b1;
    cyc(6);
    tb_vld = '0;
    cyc(3);
    check_log("rr_order", '{0, 1, 2, 0, 1, 2});

    // Single requester 1: presented the cycle after acceptance.
    glog.delete();
    tb_pl[1]      = rnd_pl();
    tb_pl[1].addr = 32'h8000_1040;
    tb_vld        = 3'b010;
    cyc(1);
    tb_vld = '0;
    check("lat_valid", 128'(l2_req.valid), 128'(1));
    check("lat_addr", 128'(l2_req.payload.addr), 128'(32'h8000_1040));
    check("lat_grant_id", 128'(o_grant_id), 128'(1));
    cyc(2);
    check_log("single_req1", '{1});

    // Requesters 0 and 2 against a stalled sink: two accepts, then drain in order.
    tb_reset = 1'b1;
    cyc(1);
    tb_reset = 1'b0;
    glog.delete();
    for (int i = 0; i < NREQ; i++) tb_pl[i] = rnd_pl();
    tb_vld    = 3'b101;
    tb_l2_rdy = 1'b0;
    cyc(5);
    tb_l2_rdy = 1'b1;
    tb_vld    = '0;
    cyc(3);
    check_log("stall_order", '{0, 2});

    // Reset with two entries queued: entries vanish, requester 0 wins first.
    tb_l2_rdy = 1'b0;
    tb_vld    = 3'b111;
    cyc(2);
    tb_reset = 1'b1;
    cyc(1);
    tb_reset = 1'b0;
    glog.delete();
    tb_l2_rdy = 1'b1;
    cyc(1);
    tb_vld = '0;
    cyc(2);
    check_log("post_reset_first", '{0});

    // Random traffic with occasional resets.
    repeat (600) begin
      tb_reset  = ($urandom_range(0, 63) == 0);
      tb_vld    = NREQ'($urandom);
      tb_l2_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) tb_pl[i] = rnd_pl();
      cyc(1);
    end
    tb_reset  = 1'b0;
    tb_vld    = '0;
    tb_l2_rdy = 1'b1;
    cyc(4);
    check("final_drain", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
